hlen_offset_ctrl: RTL and testbench

Controller that produces the packet header-length value (HLEN) consumed by the HLEN offset adder on the LW/SW address path. On each new packet committed to the packet buffer, it fetches the IP header word through a shared memory read port and extracts IHL. It then holds the computed HLEN in bytes for the EX stage. While HLEN is not yet valid, it stalls any LW/SW instruction in EX, so that memory addresses are never formed from a stale header length.

---
 rtl/hlen_offset_ctrl.sv | 140 ++++++++++++++
 tb/tb_hlen_offset_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hlen_offset_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hlen_offset_ctrl
// Description : Fetches the IP header IHL of each new packet through a shared
//               packet-buffer read port, holds HLEN in bytes for the EX-stage
//               offset adder, and stalls LW/SW in EX until HLEN is valid.
// Revision    : 1.0 - initial release
// ============================================================================
module hlen_offset_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 64,
   parameter int IHL_WORD   = 1,
   parameter int IHL_LSB    = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pkt_start,
   input  logic [ADDR_WIDTH-1:0] pkt_base_addr,
   input  logic                  pkt_done,
   output logic                  mem_rd_req,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic                  mem_rd_gnt,
   input  logic                  mem_rd_valid,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   input  logic                  LW_EX,
   input  logic                  SW_EX,
   output logic [63:0]           hlen_out,
   output logic                  hlen_valid,
   output logic                  stall_EX,
   output logic                  hdr_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_READY = 2'd3
   } state_t;

   state_t                  state;
   logic                    discard_pend;
   logic [ADDR_WIDTH-1:0]   hdr_addr;
   logic [3:0]              ihl;
   logic                    ihl_short;
   logic                    unused_data;

   // Header word address wraps naturally at the address width.
   assign hdr_addr    = pkt_base_addr + ADDR_WIDTH'(IHL_WORD);
   assign ihl         = mem_rd_data[IHL_LSB +: 4];
   assign ihl_short   = (ihl < 4'd5);
   assign unused_data = ^mem_rd_data;

   assign stall_EX = (LW_EX | SW_EX) & ~hlen_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         mem_rd_req   <= 1'b0;
         mem_rd_addr  <= '0;
         hlen_out     <= '0;
         hlen_valid   <= 1'b0;
         hdr_err      <= 1'b0;
         discard_pend <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pkt_start) begin
                  state       <= ST_REQ;
                  mem_rd_req  <= 1'b1;
                  mem_rd_addr <= hdr_addr;
                  hdr_err     <= 1'b0;
               end
            end

            ST_REQ: begin
               if (pkt_start) begin
                  mem_rd_addr <= hdr_addr;
                  hdr_err     <= 1'b0;
               end else if (mem_rd_gnt) begin
                  state      <= ST_WAIT;
                  mem_rd_req <= 1'b0;
               end
            end

            ST_WAIT: begin
               if (pkt_start) begin
                  mem_rd_addr <= hdr_addr;
                  hdr_err     <= 1'b0;
                  // A response landing in the same cycle is the stale one;
                  // drop it and reissue right away instead of waiting again.
                  if (mem_rd_valid) begin
                     state        <= ST_REQ;
                     mem_rd_req   <= 1'b1;
                     discard_pend <= 1'b0;
                  end else begin
                     discard_pend <= 1'b1;
                  end
               end else if (mem_rd_valid) begin
                  if (discard_pend) begin
                     state        <= ST_REQ;
                     mem_rd_req   <= 1'b1;
                     discard_pend <= 1'b0;
                  end else begin
                     state      <= ST_READY;
                     hlen_valid <= 1'b1;
                     if (ihl_short) begin
                        hlen_out <= 64'd20;
                        hdr_err  <= 1'b1;
                     end else begin
                        hlen_out <= {58'b0, ihl, 2'b00};
                     end
                  end
               end
            end

            ST_READY: begin
               if (pkt_start) begin
                  state       <= ST_REQ;
                  mem_rd_req  <= 1'b1;
                  mem_rd_addr <= hdr_addr;
                  hlen_valid  <= 1'b0;
                  hdr_err     <= 1'b0;
               end else if (pkt_done) begin
                  state      <= ST_IDLE;
                  hlen_valid <= 1'b0;
               end
            end

            default: begin
               state        <= ST_IDLE;
               mem_rd_req   <= 1'b0;
               hlen_valid   <= 1'b0;
               discard_pend <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hlen_offset_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hlen_offset_ctrl
// Description : Scenario and randomized checks of hlen_offset_ctrl against a
//               packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hlen_offset_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        pkt_start;
   logic [7:0]  pkt_base_addr;
   logic        pkt_done;
   logic        mem_rd_req;
   logic [7:0]  mem_rd_addr;
   logic        mem_rd_gnt;
   logic        mem_rd_valid;
   logic [63:0] mem_rd_data;
   logic        LW_EX;
   logic        SW_EX;
   logic [63:0] hlen_out;
   logic        hlen_valid;
   logic        stall_EX;
   logic        hdr_err;

   int n_cmp = 0;
   int n_err = 0;

   hlen_offset_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .pkt_start    (pkt_start),
      .pkt_base_addr(pkt_base_addr),
      .pkt_done     (pkt_done),
      .mem_rd_req   (mem_rd_req),
      .mem_rd_addr  (mem_rd_addr),
      .mem_rd_gnt   (mem_rd_gnt),
      .mem_rd_valid (mem_rd_valid),
      .mem_rd_data  (mem_rd_data),
      .LW_EX        (LW_EX),
      .SW_EX        (SW_EX),
      .hlen_out     (hlen_out),
      .hlen_valid   (hlen_valid),
      .stall_EX     (stall_EX),
      .hdr_err      (hdr_err)
   );

   always #5 clk = ~clk;

   // Reference rules, stated at packet level
   function automatic logic [63:0] model_hlen(input logic [3:0] ihl_v);
      return (ihl_v < 4'd5) ? 64'd20 : 64'(ihl_v) * 64'd4;
   endfunction

   function automatic logic [7:0] model_addr(input logic [7:0] base);
      return 8'((int'(base) + 1) % 256);
   endfunction

   function automatic logic [63:0] make_word(input logic [3:0] ihl_v);
      logic [63:0] w;
      w = {$urandom, $urandom};
      w[11:8] = ihl_v;
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one complete fetch and reports what was observed on the port.
   task automatic fetch(input logic [7:0] base, input int gd, input int rd,
                        input logic [3:0] ihl_v, output logic [7:0] addr_seen,
                        output int req_cycles, output logic valid_early);
      pkt_start = 1'b1; pkt_base_addr = base;
      step();
      pkt_start = 1'b0;
      addr_seen = mem_rd_addr;
      req_cycles = 0;
      for (int i = 0; i <= gd; i++) begin
         if (mem_rd_req && mem_rd_addr == addr_seen) req_cycles++;
         mem_rd_gnt = (i == gd);
         step();
      end
      mem_rd_gnt = 1'b0;
      for (int i = 0; i < rd; i++) begin
         if (mem_rd_req) req_cycles++;
         step();
      end
      if (mem_rd_req) req_cycles++;
      valid_early  = hlen_valid;
      mem_rd_valid = 1'b1;
      mem_rd_data  = make_word(ihl_v);
      step();
      mem_rd_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      LW_EX = 1'b1; #1;
      n_cmp++; if (stall_EX !== 1'b1) begin n_err++; $display("FAIL reset_stall actual=%b required=1", stall_EX); end
      n_cmp++; if (hlen_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid actual=%b required=0", hlen_valid); end
      n_cmp++; if (hlen_out !== 64'd0) begin n_err++; $display("FAIL reset_hlen actual=%0d required=0", hlen_out); end
      n_cmp++; if (mem_rd_req !== 1'b0) begin n_err++; $display("FAIL reset_req actual=%b required=0", mem_rd_req); end
      n_cmp++; if (mem_rd_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr actual=%h required=00", mem_rd_addr); end
      n_cmp++; if (hdr_err !== 1'b0) begin n_err++; $display("FAIL reset_err actual=%b required=0", hdr_err); end
      LW_EX = 1'b0;
   endtask

   task automatic test_basic();
      pkt_start = 1'b1; pkt_base_addr = 8'h10;
      step();
      pkt_start = 1'b0;
      n_cmp++; if (mem_rd_req !== 1'b1 || mem_rd_addr !== 8'h11) begin n_err++; $display("FAIL basic_req actual=%b/%h required=1/11", mem_rd_req, mem_rd_addr); end
      mem_rd_gnt = 1'b1;
      step();
      mem_rd_gnt = 1'b0;
      n_cmp++; if (mem_rd_req !== 1'b0) begin n_err++; $display("FAIL basic_wait_req actual=%b required=0", mem_rd_req); end
      mem_rd_valid = 1'b1; mem_rd_data = make_word(4'd5);
      step();
      mem_rd_valid = 1'b0;
      n_cmp++; if (hlen_valid !== 1'b1 || hlen_out !== 64'd20) begin n_err++; $display("FAIL basic_hlen actual=%b/%0d required=1/20", hlen_valid, hlen_out); end
      SW_EX = 1'b1; #1;
      n_cmp++; if (stall_EX !== 1'b0) begin n_err++; $display("FAIL basic_stall actual=%b required=0", stall_EX); end
      SW_EX = 1'b0;
   endtask

   task automatic test_grant_delay();
      logic [7:0] a; int rc; logic early;
      fetch(8'h30, 3, 0, 4'd15, a, rc, early);
      n_cmp++; if (rc !== 4) begin n_err++; $display("FAIL gd_req_cycles actual=%0d required=4", rc); end
      n_cmp++; if (early !== 1'b0 || hlen_valid !== 1'b1 || hlen_out !== 64'd60) begin n_err++; $display("FAIL gd_hlen actual=%b/%b/%0d required=0/1/60", early, hlen_valid, hlen_out); end
      pkt_done = 1'b1;
      step();
      pkt_done = 1'b0;
      n_cmp++; if (hlen_valid !== 1'b0 || hlen_out !== 64'd60) begin n_err++; $display("FAIL gd_done actual=%b/%0d required=0/60", hlen_valid, hlen_out); end
   endtask

   task automatic test_wrap_err();
      logic [7:0] a; int rc; logic early;
      fetch(8'hFF, 0, 1, 4'd3, a, rc, early);
      n_cmp++; if (a !== 8'h00) begin n_err++; $display("FAIL wrap_addr actual=%h required=00", a); end
      n_cmp++; if (hlen_out !== 64'd20 || hdr_err !== 1'b1) begin n_err++; $display("FAIL wrap_err actual=%0d/%b required=20/1", hlen_out, hdr_err); end
      pkt_start = 1'b1; pkt_base_addr = 8'h05;
      step();
      pkt_start = 1'b0;
      n_cmp++; if (hdr_err !== 1'b0 || mem_rd_addr !== 8'h06) begin n_err++; $display("FAIL err_clear actual=%b/%h required=0/06", hdr_err, mem_rd_addr); end
      mem_rd_gnt = 1'b1; step(); mem_rd_gnt = 1'b0;
      mem_rd_valid = 1'b1; mem_rd_data = make_word(4'd8); step(); mem_rd_valid = 1'b0;
      n_cmp++; if (hlen_out !== 64'd32) begin n_err++; $display("FAIL restart_hlen actual=%0d required=32", hlen_out); end
   endtask

   task automatic test_discard();
      pkt_start = 1'b1; pkt_base_addr = 8'h20; step(); pkt_start = 1'b0;
      mem_rd_gnt = 1'b1; step(); mem_rd_gnt = 1'b0;
      pkt_start = 1'b1; pkt_base_addr = 8'h40; step(); pkt_start = 1'b0;
      n_cmp++; if (mem_rd_req !== 1'b0 || hlen_valid !== 1'b0) begin n_err++; $display("FAIL disc_wait actual=%b/%b required=0/0", mem_rd_req, hlen_valid); end
      mem_rd_valid = 1'b1; mem_rd_data = make_word(4'd6); step(); mem_rd_valid = 1'b0;
      n_cmp++; if (mem_rd_req !== 1'b1 || mem_rd_addr !== 8'h41) begin n_err++; $display("FAIL disc_reissue actual=%b/%h required=1/41", mem_rd_req, mem_rd_addr); end
      n_cmp++; if (hlen_valid !== 1'b0 || hlen_out !== 64'd32) begin n_err++; $display("FAIL disc_drop actual=%b/%0d required=0/32", hlen_valid, hlen_out); end
      mem_rd_gnt = 1'b1; step(); mem_rd_gnt = 1'b0;
      mem_rd_valid = 1'b1; mem_rd_data = make_word(4'd7); step(); mem_rd_valid = 1'b0;
      n_cmp++; if (hlen_valid !== 1'b1 || hlen_out !== 64'd28) begin n_err++; $display("FAIL disc_hlen actual=%b/%0d required=1/28", hlen_valid, hlen_out); end
   endtask

   task automatic test_start_done();
      pkt_start = 1'b1; pkt_done = 1'b1; pkt_base_addr = 8'h80;
      step();
      pkt_start = 1'b0; pkt_done = 1'b0;
      n_cmp++; if (mem_rd_req !== 1'b1 || hlen_valid !== 1'b0 || mem_rd_addr !== 8'h81) begin n_err++; $display("FAIL start_done actual=%b/%b/%h required=1/0/81", mem_rd_req, hlen_valid, mem_rd_addr); end
      pkt_done = 1'b1; step(); pkt_done = 1'b0;
      n_cmp++; if (mem_rd_req !== 1'b1) begin n_err++; $display("FAIL done_in_req actual=%b required=1", mem_rd_req); end
   endtask

   task automatic test_reset_mid();
      mem_rd_gnt = 1'b1; step(); mem_rd_gnt = 1'b0;
      do_reset();
      n_cmp++; if (mem_rd_req !== 1'b0 || hlen_valid !== 1'b0 || hlen_out !== 64'd0) begin n_err++; $display("FAIL rst_mid actual=%b/%b/%0d required=0/0/0", mem_rd_req, hlen_valid, hlen_out); end
      mem_rd_valid = 1'b1; mem_rd_data = make_word(4'd9); step(); mem_rd_valid = 1'b0;
      step();
      n_cmp++; if (hlen_valid !== 1'b0 || hlen_out !== 64'd0) begin n_err++; $display("FAIL late_valid actual=%b/%0d required=0/0", hlen_valid, hlen_out); end
   endtask

   task automatic test_random();
      logic [7:0] base, a; logic [3:0] ihl_v; int gd, rd, rc; logic early, lw, sw;
      for (int it = 0; it < 30; it++) begin
         base  = 8'($urandom);
         ihl_v = 4'($urandom);
         gd    = int'($urandom_range(0, 3));
         rd    = int'($urandom_range(0, 3));
         fetch(base, gd, rd, ihl_v, a, rc, early);
         n_cmp++; if (a !== model_addr(base) || rc !== gd + 1) begin n_err++; $display("FAIL rnd_req it=%0d actual=%h/%0d required=%h/%0d", it, a, rc, model_addr(base), gd + 1); end
         n_cmp++; if (early !== 1'b0 || hlen_valid !== 1'b1) begin n_err++; $display("FAIL rnd_latency it=%0d actual=%b/%b required=0/1", it, early, hlen_valid); end
         n_cmp++; if (hlen_out !== model_hlen(ihl_v) || hdr_err !== (ihl_v < 4'd5)) begin n_err++; $display("FAIL rnd_hlen it=%0d ihl=%0d actual=%0d/%b required=%0d/%b", it, ihl_v, hlen_out, hdr_err, model_hlen(ihl_v), ihl_v < 4'd5); end
         lw = 1'($urandom); sw = 1'($urandom);
         LW_EX = lw; SW_EX = sw; #1;
         n_cmp++; if (stall_EX !== 1'b0) begin n_err++; $display("FAIL rnd_stall_ready it=%0d actual=%b required=0", it, stall_EX); end
         if (($urandom & 1) == 1) begin
            pkt_done = 1'b1; step(); pkt_done = 1'b0;
            n_cmp++; if (stall_EX !== (lw | sw) || hlen_out !== model_hlen(ihl_v)) begin n_err++; $display("FAIL rnd_done it=%0d actual=%b/%0d required=%b/%0d", it, stall_EX, hlen_out, lw | sw, model_hlen(ihl_v)); end
         end
         LW_EX = 1'b0; SW_EX = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1; pkt_start = 1'b0; pkt_base_addr = 8'h00; pkt_done = 1'b0;
      mem_rd_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = 64'd0;
      LW_EX = 1'b0; SW_EX = 1'b0;
      test_reset();
      test_basic();
      test_grant_delay();
      test_wrap_err();
      test_discard();
      test_start_done();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
